// File: rtl/comparador_pkg.sv
// Shared definitions for the comparator result monitor: FSM state encoding
// and the default report window length.
package comparador_pkg;

    // Accepted samples per report window unless overridden.
    localparam int unsigned WINDOW_DEF = 16;

    // Monitor control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/contador_ce.sv
// CW-bit up counter with synchronous clear and count enable.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (forces zero)
//   clr  synchronous clear (forces zero, wins over en)
//   en   increment by one this edge
//   cnt  current count
module contador_ce #(
    parameter int unsigned CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/comparador_monitor.sv
// Comparator result monitor: after start, classifies WINDOW accepted Y/Z
// comparator results into greater / equal / less / error counts, then
// presents them with a valid/ready handshake.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, abort    open a new window / discard the current one
//   in_valid, Y, Z  comparator result sample ("greater", "equal")
//   out_ready       consumer accepts the report
//   busy            window is accumulating
//   out_valid       report counts are valid
//   cnt_gt/eq/lt/err per-window counts (Y only, Z only, neither, both)
import comparador_pkg::*;

module comparador_monitor #(
    parameter int unsigned WINDOW = WINDOW_DEF,
    parameter int unsigned CW     = $clog2(WINDOW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic          Y,
    input  logic          Z,
    input  logic          out_ready,
    output logic          busy,
    output logic          out_valid,
    output logic [CW-1:0] cnt_gt,
    output logic [CW-1:0] cnt_eq,
    output logic [CW-1:0] cnt_lt,
    output logic [CW-1:0] cnt_err
);

    state_t        state;
    logic [CW-1:0] idx;

    logic accept_c;
    logic last_c;
    logic open_c;
    logic drop_c;
    logic clr_c;

    // A sample counts only while accumulating and not being aborted.
    assign accept_c = (state == ST_ACCUM) && in_valid && !abort;
    assign last_c   = accept_c && (idx == CW'(WINDOW - 1));

    // New window opens from IDLE, or straight out of an accepted REPORT.
    assign open_c = !abort && start &&
                    ((state == ST_IDLE) || ((state == ST_REPORT) && out_ready));
    // Abort only matters once a window exists.
    assign drop_c = abort && (state != ST_IDLE);
    assign clr_c  = open_c || drop_c;

    // Control FSM; busy and out_valid are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (open_c) begin
                        state <= ST_ACCUM;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end else if (last_c) begin
                        state     <= ST_REPORT;
                        idx       <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else if (accept_c) begin
                        idx <= idx + CW'(1);
                    end
                end
                ST_REPORT: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        idx       <= '0;
                        if (start) begin
                            state <= ST_ACCUM;
                            busy  <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    idx       <= '0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // One counter per result class; exactly one enable fires per accepted sample.
    contador_ce #(.CW(CW)) u_cnt_gt (
        .clk (clk),
        .rst (rst),
        .clr (clr_c),
        .en  (accept_c && Y && !Z),
        .cnt (cnt_gt)
    );

    contador_ce #(.CW(CW)) u_cnt_eq (
        .clk (clk),
        .rst (rst),
        .clr (clr_c),
        .en  (accept_c && !Y && Z),
        .cnt (cnt_eq)
    );

    contador_ce #(.CW(CW)) u_cnt_lt (
        .clk (clk),
        .rst (rst),
        .clr (clr_c),
        .en  (accept_c && !Y && !Z),
        .cnt (cnt_lt)
    );

    contador_ce #(.CW(CW)) u_cnt_err (
        .clk (clk),
        .rst (rst),
        .clr (clr_c),
        .en  (accept_c && Y && Z),
        .cnt (cnt_err)
    );

endmodule

// File: tb/tb_comparador_monitor.sv
// Self-checking bench for comparador_monitor (WINDOW=16, CW=5).
module tb_comparador_monitor;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       in_valid;
    logic       y;
    logic       z;
    logic       out_ready;
    logic       busy;
    logic       out_valid;
    logic [4:0] cnt_gt;
    logic [4:0] cnt_eq;
    logic [4:0] cnt_lt;
    logic [4:0] cnt_err;

    int total;
    int bad;

    comparador_monitor #(.WINDOW(16), .CW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .Y         (y),
        .Z         (z),
        .out_ready (out_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .cnt_gt    (cnt_gt),
        .cnt_eq    (cnt_eq),
        .cnt_lt    (cnt_lt),
        .cnt_err   (cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input bits: {rst, start, abort, in_valid, y, z, out_ready}; flags: {busy, out_valid}.
    typedef struct {
        logic [6:0] in_bits;
        logic [1:0] flags;
        logic [4:0] gt;
        logic [4:0] eq;
        logic [4:0] lt;
        logic [4:0] err;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic [6:0] b, input logic [1:0] f,
                                input logic [4:0] g, input logic [4:0] e,
                                input logic [4:0] l, input logic [4:0] x);
        vec_t v;
        v.in_bits = b;
        v.flags   = f;
        v.gt      = g;
        v.eq      = e;
        v.lt      = l;
        v.err     = x;
        return v;
    endfunction

    // Apply inputs, let one rising edge pass, settle away from the edge.
    task automatic drive(input logic [6:0] b);
        {rst, start, abort, in_valid, y, z, out_ready} = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic eb, input logic eov,
                       input logic [4:0] eg, input logic [4:0] ee,
                       input logic [4:0] el, input logic [4:0] ex);
        total++;
        if (busy !== eb || out_valid !== eov || cnt_gt !== eg ||
            cnt_eq !== ee || cnt_lt !== el || cnt_err !== ex) begin
            bad++;
            $display("FAIL %s: got busy=%b ov=%b gt=%0d eq=%0d lt=%0d err=%0d, need busy=%b ov=%b gt=%0d eq=%0d lt=%0d err=%0d",
                     nm, busy, out_valid, cnt_gt, cnt_eq, cnt_lt, cnt_err,
                     eb, eov, eg, ee, el, ex);
        end
    endtask

    task automatic chk_flags(input string nm, input logic eb, input logic eov);
        total++;
        if (busy !== eb || out_valid !== eov) begin
            bad++;
            $display("FAIL %s: got busy=%b ov=%b, need busy=%b ov=%b",
                     nm, busy, out_valid, eb, eov);
        end
    endtask

    initial begin
        logic [3:0] sw;
        int         j;
        total = 0;
        bad   = 0;
        {rst, start, abort, in_valid, y, z, out_ready} = 7'b1000000;

        tbl[0]  = mk(7'b1000000, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0); // reset
        tbl[1]  = mk(7'b0000000, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0); // idle
        tbl[2]  = mk(7'b0110000, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0); // start+abort in idle
        tbl[3]  = mk(7'b0001100, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0); // sample in idle ignored
        tbl[4]  = mk(7'b0100000, 2'b10, 5'd0, 5'd0, 5'd0, 5'd0); // start
        tbl[5]  = mk(7'b0001100, 2'b10, 5'd1, 5'd0, 5'd0, 5'd0); // Y only
        tbl[6]  = mk(7'b0001010, 2'b10, 5'd1, 5'd1, 5'd0, 5'd0); // Z only
        tbl[7]  = mk(7'b0001000, 2'b10, 5'd1, 5'd1, 5'd1, 5'd0); // neither
        tbl[8]  = mk(7'b0001110, 2'b10, 5'd1, 5'd1, 5'd1, 5'd1); // both
        tbl[9]  = mk(7'b0000110, 2'b10, 5'd1, 5'd1, 5'd1, 5'd1); // bubble
        tbl[10] = mk(7'b0101100, 2'b10, 5'd2, 5'd1, 5'd1, 5'd1); // start ignored in accum
        tbl[11] = mk(7'b0111100, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0); // abort wins
        tbl[12] = mk(7'b0000000, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0); // idle after abort

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].in_bits);
            chk($sformatf("vec%0d", i), tbl[i].flags[1], tbl[i].flags[0],
                tbl[i].gt, tbl[i].eq, tbl[i].lt, tbl[i].err);
        end

        // Exhaustive 2-bit a vs b sweep: 6 greater, 4 equal, 6 less.
        drive(7'b0100000);
        for (int i = 0; i < 16; i++) begin
            sw = 4'(i);
            drive({4'b0001, sw[3:2] > sw[1:0], sw[3:2] == sw[1:0], 1'b0});
            if (i < 15) chk_flags($sformatf("sweep_busy%0d", i), 1'b1, 1'b0);
        end
        chk("sweep_report", 1'b0, 1'b1, 5'd6, 5'd4, 5'd6, 5'd0);
        drive(7'b0000001);
        chk("sweep_ack_idle", 1'b0, 1'b0, 5'd6, 5'd4, 5'd6, 5'd0);
        drive(7'b0000000);
        chk("idle_holds_counts", 1'b0, 1'b0, 5'd6, 5'd4, 5'd6, 5'd0);

        // 16 valid samples with 8 bubbles (bubbles carry Y=Z=1 and must not count).
        drive(7'b0100000);
        j = 0;
        for (int k = 0; k < 24; k++) begin
            if (k % 3 == 0) begin
                drive(7'b0000110);
            end else begin
                drive({4'b0001, (j % 2 == 0), 1'b0, 1'b0});
                j++;
            end
            if (k < 23) chk_flags($sformatf("bubble_busy%0d", k), 1'b1, 1'b0);
        end
        chk("bubble_report", 1'b0, 1'b1, 5'd8, 5'd0, 5'd8, 5'd0);

        // Report held with out_ready=0; start and samples ignored.
        for (int k = 0; k < 5; k++) begin
            drive(7'b0101100);
            chk($sformatf("hold%0d", k), 1'b0, 1'b1, 5'd8, 5'd0, 5'd8, 5'd0);
        end
        drive(7'b0100001);
        chk("back_to_back", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);

        // Abort after 7 samples, then a window of all Y=Z=1.
        for (int k = 0; k < 7; k++) drive(7'b0001100);
        chk("seven_gt", 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 5'd0);
        drive(7'b0011100);
        chk("abort_mid", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        drive(7'b0100000);
        for (int k = 0; k < 16; k++) drive(7'b0001110);
        chk("all_err", 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd16);
        drive(7'b0000001);
        chk("err_ack", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd16);

        // Reset mid-window at sample 10, with start and samples active.
        drive(7'b0100000);
        for (int k = 0; k < 10; k++) drive(7'b0001100);
        chk("ten_gt", 1'b1, 1'b0, 5'd10, 5'd0, 5'd0, 5'd0);
        drive(7'b1101100);
        chk("rst_mid", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        drive(7'b1101100);
        chk("rst_held", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        drive(7'b0000000);
        chk("after_rst", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);

        // Reset while in REPORT.
        drive(7'b0100000);
        for (int k = 0; k < 16; k++) drive(7'b0001000);
        chk("all_lt", 1'b0, 1'b1, 5'd0, 5'd0, 5'd16, 5'd0);
        drive(7'b1100000);
        chk("rst_report", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);

        // Abort in REPORT wins over start and out_ready.
        drive(7'b0100000);
        for (int k = 0; k < 16; k++) drive(7'b0001010);
        chk("all_eq", 1'b0, 1'b1, 5'd0, 5'd16, 5'd0, 5'd0);
        drive(7'b0110001);
        chk("abort_report", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        drive(7'b0000000);
        chk("idle_final", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comparador_monitor.md
COMPARADOR_MONITOR -- requirements
Module: comparador_monitor

Interface
REQ-001 SHALL have parameter WINDOW, default 16, meaning the number of accepted samples per report window (range 2..255).
REQ-002 SHALL have parameter CW, default 5, meaning the counter width; CW SHALL equal clog2(WINDOW+1).
REQ-003 clk  input  1  the single clock; all state SHALL change on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to open a new window.
REQ-006 abort  input  1  discards the current window.
REQ-007 in_valid  input  1  Y/Z hold a comparator result this cycle.
REQ-008 Y  input  1  comparator "greater" result.
REQ-009 Z  input  1  comparator "equal" result.
REQ-010 out_ready  input  1  consumer accepts the report.
REQ-011 busy  output  1  high while the window is accumulating.
REQ-012 out_valid  output  1  report counts are valid.
REQ-013 cnt_gt, cnt_eq, cnt_lt, cnt_err  output  CW each  per-window counts (Y only, Z only, neither, both).

Function
REQ-014 SHALL implement a three-state FSM: IDLE, ACCUM and REPORT.
REQ-015 IDLE: start=1 SHALL move to ACCUM and clear all four counts and the sample index on the same edge.
REQ-016 ACCUM: each cycle with in_valid=1 SHALL increment exactly one count: Y&!Z to cnt_gt, Z&!Y to cnt_eq, !Y&!Z to cnt_lt, Y&Z to cnt_err.
REQ-017 ACCUM: in_valid=0 SHALL leave the counts and the index unchanged.
REQ-018 ACCUM: the accepted sample at index WINDOW-1 SHALL be counted, and the FSM SHALL enter REPORT on that edge.
REQ-019 out_valid SHALL rise in the cycle after the last accepted sample (latency 1).
REQ-020 REPORT: out_valid SHALL be 1 and all counts SHALL hold stable until out_ready=1.
REQ-021 REPORT with out_ready=1 and start=0 SHALL return to IDLE; out_valid SHALL be 0 in the next cycle.
REQ-022 REPORT with out_ready=1 and start=1 SHALL go directly to ACCUM with the counts cleared (back-to-back windows).
REQ-023 start SHALL be ignored in ACCUM, and in REPORT while out_ready=0.
REQ-024 abort=1 in ACCUM or REPORT SHALL force IDLE and zero all counts on the next edge, regardless of in_valid, start and out_ready.
REQ-025 abort=1 in IDLE SHALL have no effect, and SHALL win over start in the same cycle.
REQ-026 At REPORT, cnt_gt+cnt_eq+cnt_lt+cnt_err SHALL equal WINDOW; no count can overflow, because each is at most WINDOW.
REQ-027 busy SHALL be 1 exactly when the state is ACCUM.
REQ-028 Counts SHALL remain readable in IDLE, holding the last window's values until the next start or abort.

Reset
REQ-029 rst=1 SHALL force IDLE, busy=0, out_valid=0, all counts 0 and index 0 on the next edge.
REQ-030 rst SHALL take priority over abort, start and all other inputs, including mid-window.

Structure
REQ-031 The state encoding (IDLE, ACCUM, REPORT) and the WINDOW default SHALL live in the shared package comparador_pkg.
REQ-032 One sub-module, contador_ce (a CW-bit counter with synchronous clear and enable), SHALL be instantiated four times, once per count.

Verification
REQ-033 start, then the 16 samples of an exhaustive 4-bit sweep with 6 Y-only, 4 Z-only and 6 neither -> out_valid 1 cycle after the 16th sample, counts 6/4/6/0.
REQ-034 start, 16 samples with 8 in_valid=0 bubbles interleaved -> report appears only after the 16th valid sample, bubbles are not counted, and busy stays 1 throughout.
REQ-035 REPORT held with out_ready=0 for 5 cycles -> counts stable; then out_ready=1 with start=1 -> next cycle busy=1, all counts 0.
REQ-036 abort after 7 samples -> next cycle IDLE, counts 0; a later start with 16 samples of Y=Z=1 -> cnt_err=16, other counts 0.
REQ-037 rst asserted at sample 10 and in REPORT -> next cycle all outputs 0; start and Y/Z are ignored while rst=1.
REQ-038 start and abort asserted together in IDLE -> state stays IDLE and busy stays 0.
